// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings, default frame geometry
// and parity sense. Used by uart_rx (and uart_tx).
package uart_pkg;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int OVS_DEF     = 16;

  // 0 = even parity, 1 = odd parity (only meaningful with UART_RX_PARITY_EN).
  localparam logic PARITY_ODD = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; reset value is a parameter
// so an idle-high line does not look like an edge when reset is released.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver on a shared 16x oversampling baud_tick; emits each byte with a
// one-cycle rx_done_tick and a framing-error flag. Define UART_RX_PARITY_EN for 8E1/8O1.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF,
  parameter int OVS     = OVS_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            baud_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  uart_state_e     state_reg, state_next;
  logic [3:0]      s_reg, s_next;
  logic [2:0]      n_reg, n_next;
  logic [DBIT-1:0] d_reg, d_next, data_next;
  logic            done_next, ferr_next;
  logic            brk_reg, brk_next;
  logic            rx_s;

`ifdef UART_RX_PARITY_EN
  logic perr_pend, perr_pend_next, perr_next;
`endif

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      s_reg        <= '0;
      n_reg        <= '0;
      d_reg        <= '0;
      rx_data      <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      brk_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      s_reg        <= s_next;
      n_reg        <= n_next;
      d_reg        <= d_next;
      rx_data      <= data_next;
      rx_done_tick <= done_next;
      frame_err    <= ferr_next;
      brk_reg      <= brk_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perr_pend  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      perr_pend  <= perr_pend_next;
      parity_err <= perr_next;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    d_next     = d_reg;
    data_next  = rx_data;
    done_next  = 1'b0;
    ferr_next  = frame_err;
    brk_next   = brk_reg;
`ifdef UART_RX_PARITY_EN
    perr_pend_next = perr_pend;
    perr_next      = parity_err;
`endif

    // A low stop bit (break) locks out new starts until the line has been seen high.
    if (rx_s) brk_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        s_next = '0;
        n_next = '0;
        if (!rx_s && !brk_reg) state_next = START;
      end

      START: begin
        if (baud_tick) begin
          if (s_reg == 4'(OVS/2 - 1)) begin
            s_next     = '0;
            state_next = rx_s ? IDLE : DATA;
          end else begin
            s_next = s_reg + 4'd1;
          end
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (s_reg == 4'(OVS - 1)) begin
            s_next = '0;
            d_next = {rx_s, d_reg[DBIT-1:1]};
            if (n_reg == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n_reg + 3'd1;
            end
          end else begin
            s_next = s_reg + 4'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          if (s_reg == 4'(OVS - 1)) begin
            s_next         = '0;
            perr_pend_next = rx_s ^ (^d_reg) ^ PARITY_ODD;
            state_next     = STOP;
          end else begin
            s_next = s_reg + 4'd1;
          end
        end
      end
`endif

      STOP: begin
        if (baud_tick) begin
          if (s_reg == 4'(SB_TICK - 1)) begin
            data_next  = d_reg;
            ferr_next  = ~rx_s;
            brk_next   = ~rx_s;
            done_next  = 1'b1;
            state_next = IDLE;
`ifdef UART_RX_PARITY_EN
            perr_next  = perr_pend;
`endif
          end else begin
            s_next = s_reg + 4'd1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serializer drives 8N1 frames at 64 clk/bit with
// baud_tick every 4 clk; a monitor checks each rx_done_tick against queued expectations.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLKS = 64;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   errors = 0;
  int   cyc = 0;
  int   tick_div = 0;
  int   pulse_cyc = 0;
  int   pulse_count = 0;
  int   start_cyc = 0;
  logic prev_done = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx dut (
    .clk          (clk),
    .reset        (reset),
    .baud_tick    (baud_tick),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    tick_div  <= (tick_div == 3) ? 0 : tick_div + 1;
    baud_tick <= (tick_div == 3);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      pulse_cyc = cyc;
      pulse_count++;
      check("done_one_cycle", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_pulse: got rx_data=0x%0h, expected no pulse", rx_data);
      end else begin
        e = sb.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
        check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
      end
    end
    prev_done = rx_done_tick;
  end

  task automatic expect_byte(input logic [7:0] d, input logic ferr, input logic perr);
    exp_t x;
    x.data = d;
    x.ferr = ferr;
    x.perr = perr;
    sb.push_back(x);
  endtask

  // Called at a negedge; returns at a negedge with the line idle so frames can abut.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ PARITY_ODD ^ par_flip;
    repeat (BIT_CLKS) @(negedge clk);
`endif
    rx = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending bytes, expected 0", name, sb.size());
      sb.delete();
    end
    repeat (2 * BIT_CLKS) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    check({name, "_done"}, {31'd0, rx_done_tick}, 32'd0);
    check({name, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({name, "_parity_err"}, {31'd0, parity_err}, 32'd0);
  endtask

  initial begin
    int n0;
    int lat;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // 1: single byte plus stop-sample latency (9.5 bits = 608 clk after the start edge).
    expect_byte(8'h55, 1'b0, 1'b0);
    send_byte(8'h55, 1'b1);
    drain("t1");
    lat = pulse_cyc - start_cyc;
    check("t1_latency_in_600_616", {31'd0, (lat >= 600 && lat <= 616)}, 32'd1);

    // 2: back-to-back frames with no idle gap.
    expect_byte(8'hA3, 1'b0, 1'b0);
    expect_byte(8'h0F, 1'b0, 1'b0);
    send_byte(8'hA3, 1'b1);
    send_byte(8'h0F, 1'b1);
    drain("t2");

    // 3: 3-tick start glitch must be rejected, then a real frame received.
    n0 = pulse_count;
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("t3_glitch_no_pulse", pulse_count - n0, 32'd0);
    expect_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b1);
    drain("t3");

    // 4: bad stop bit still delivers the byte with frame_err; next good byte clears it.
    expect_byte(8'hFF, 1'b1, 1'b0);
    send_byte(8'hFF, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    expect_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h01, 1'b1);
    drain("t4");

    // 5: reset in the middle of 0x81's data bits; only 0x7E may be delivered.
    fork
      send_byte(8'h81, 1'b1);
      begin
        repeat (3 * BIT_CLKS) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("t5_in_reset");
        repeat (3 * BIT_CLKS) @(negedge clk);
        check_reset_outputs("t5_late_reset");
      end
    join
    @(negedge clk);
    reset = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    expect_byte(8'h7E, 1'b0, 1'b0);
    send_byte(8'h7E, 1'b1);
    drain("t5");

`ifdef UART_RX_PARITY_EN
    // 6: 0x07 has three ones, so the even parity bit is 1; flipping it must flag parity_err.
    expect_byte(8'h07, 1'b0, 1'b0);
    send_byte(8'h07, 1'b1);
    drain("t6_good");
    par_flip = 1'b1;
    expect_byte(8'h07, 1'b0, 1'b1);
    send_byte(8'h07, 1'b1);
    par_flip = 1'b0;
    drain("t6_bad");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
